// File: rtl/partition_pkg.sv
// Shared definitions for the partition address translator: FSM encodings,
// the supervisor (SO) table index and the reset partition layout.
package partition_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam int SO_IDX = 0;

  function automatic logic [63:0] reset_base(input int i, input int part_size);
    return 64'(i) * 64'(part_size);
  endfunction

endpackage

// File: rtl/partition_table.sv
// Base/limit register file: one synchronous write port, one async read port.
// Entry i resets to base i*PART_SIZE, limit PART_SIZE; entry 0 (SO) resets to 0/0.
module partition_table
  import partition_pkg::*;
#(
  parameter int NUM_PROC  = 16,
  parameter int PART_SIZE = 150,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = $clog2(NUM_PROC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] wbase,
  input  logic [ADDR_W-1:0] wlimit,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] rbase,
  output logic [ADDR_W-1:0] rlimit
);

  logic [ADDR_W-1:0] base_q  [NUM_PROC];
  logic [ADDR_W-1:0] limit_q [NUM_PROC];

  function automatic logic [ADDR_W-1:0] init_base(input int i);
    logic [63:0] v;
    v = reset_base(i, PART_SIZE);
    return v[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROC; i++) begin
        base_q[i]  <= init_base(i);
        limit_q[i] <= (i == SO_IDX) ? '0 : PART_SIZE[ADDR_W-1:0];
      end
    end else if (we) begin
      base_q[widx]  <= wbase;
      limit_q[widx] <= wlimit;
    end
  end

  assign rbase  = base_q[ridx];
  assign rlimit = limit_q[ridx];

endmodule

// File: rtl/partition_addr_translator.sv
// Logical-to-physical translation against the active partition, 1 registered cycle;
// no backpressure: requests and table writes arriving during a context switch are dropped.
module partition_addr_translator
  import partition_pkg::*;
#(
  parameter int NUM_PROC  = 16,
  parameter int PART_SIZE = 150,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = $clog2(NUM_PROC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              switch_req,
  input  logic [IDX_W-1:0]  switch_idx,
  output logic              switch_ack,
  output logic              busy,
  output logic [IDX_W-1:0]  cur_idx,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  output logic              fault_sticky,
  input  logic              fault_clear
);

  localparam logic [IDX_W:0]   NUM_PROC_X = (IDX_W+1)'(NUM_PROC);
  localparam logic [IDX_W-1:0] SO         = IDX_W'(SO_IDX);

  logic [1:0]        state;
  logic [IDX_W-1:0]  lat_idx;
  logic [ADDR_W-1:0] act_base, act_limit;
  logic [ADDR_W-1:0] rbase, rlimit;
  logic [IDX_W-1:0]  ridx;
  logic [ADDR_W:0]   sum;
  logic idle, is_so, lat_bad, cfg_bad_idx, cfg_ok, cfg_fault;
  logic xl_fire, xl_fault, load_fault, fault_set;

  assign idle        = (state == IDLE);
  assign is_so       = (cur_idx == SO);
  assign lat_bad     = ({1'b0, lat_idx} >= NUM_PROC_X);
  assign ridx        = lat_bad ? SO : lat_idx;
  assign cfg_bad_idx = ({1'b0, cfg_idx} >= NUM_PROC_X);
  assign cfg_ok      = cfg_we && idle && is_so && !cfg_bad_idx;
  assign cfg_fault   = cfg_we && idle && (!is_so || cfg_bad_idx);

  // Carry-out faults even for the SO, which otherwise skips the limit check
  assign sum        = {1'b0, act_base} + {1'b0, req_addr};
  assign xl_fire    = req_valid && idle;
  assign xl_fault   = sum[ADDR_W] || (!is_so && (req_addr >= act_limit));
  assign load_fault = (state == LOAD) && lat_bad;
  assign fault_set  = (xl_fire && xl_fault) || cfg_fault || load_fault;

  assign busy       = !idle;
  assign switch_ack = (state == ACK);

  partition_table #(
    .NUM_PROC (NUM_PROC),
    .PART_SIZE(PART_SIZE),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_ok),
    .widx  (cfg_idx),
    .wbase (cfg_base),
    .wlimit(cfg_limit),
    .ridx  (ridx),
    .rbase (rbase),
    .rlimit(rlimit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_idx   <= '0;
      cur_idx   <= '0;
      act_base  <= '0;
      act_limit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (switch_req) begin
            state   <= LOAD;
            lat_idx <= switch_idx;
          end
          // The SO edits its own entry: keep the active copy coherent
          if (cfg_ok && (cfg_idx == SO)) begin
            act_base  <= cfg_base;
            act_limit <= cfg_limit;
          end
        end
        LOAD: begin
          act_base  <= rbase;
          act_limit <= rlimit;
          cur_idx   <= ridx;
          state     <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_addr     <= '0;
      rsp_fault    <= 1'b0;
      fault_sticky <= 1'b0;
    end else begin
      rsp_valid <= xl_fire;
      rsp_fault <= xl_fire && xl_fault;
      if (xl_fire) rsp_addr <= xl_fault ? '0 : sum[ADDR_W-1:0];
      if (fault_set)        fault_sticky <= 1'b1;
      else if (fault_clear) fault_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_partition_addr_translator.sv
// Directed bench: expected responses queued at issue, checked by a separate monitor.
module tb_partition_addr_translator;

  logic        clk;
  logic        rst_n;
  logic        switch_req;
  logic [3:0]  switch_idx;
  logic        switch_ack;
  logic        busy;
  logic [3:0]  cur_idx;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [31:0] cfg_base;
  logic [31:0] cfg_limit;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic        rsp_fault;
  logic        fault_sticky;
  logic        fault_clear;

  partition_addr_translator #(
    .NUM_PROC (12),
    .PART_SIZE(150),
    .ADDR_W   (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .switch_req  (switch_req),
    .switch_idx  (switch_idx),
    .switch_ack  (switch_ack),
    .busy        (busy),
    .cur_idx     (cur_idx),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_base    (cfg_base),
    .cfg_limit   (cfg_limit),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_addr    (rsp_addr),
    .rsp_fault   (rsp_fault),
    .fault_sticky(fault_sticky),
    .fault_clear (fault_clear)
  );

  typedef struct {
    logic [31:0] addr;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_addr", rsp_addr, e.addr);
        chk("rsp_fault", rsp_fault, e.fault);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic translate(input logic [31:0] a, input logic [31:0] ea, input logic ef);
    exp_t e;
    e.addr = ea; e.fault = ef; e.cyc = cyc + 1;
    q.push_back(e);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_switch(input logic [3:0] idx, input logic [3:0] exp_idx);
    switch_req = 1'b1;
    switch_idx = idx;
    @(negedge clk);
    switch_req = 1'b0;
    chk("sw_busy_load", busy, 1);
    chk("sw_noack_load", switch_ack, 0);
    @(negedge clk);
    chk("sw_ack", switch_ack, 1);
    chk("sw_cur_idx", cur_idx, exp_idx);
    @(negedge clk);
    chk("sw_ack_drop", switch_ack, 0);
    chk("sw_busy_drop", busy, 0);
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [31:0] b, input logic [31:0] l);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = b; cfg_limit = l;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_sticky();
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    chk("sticky_cleared", fault_sticky, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    exp_t e;
    rst_n = 1'b0; switch_req = 1'b0; switch_idx = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_base = '0; cfg_limit = '0; req_valid = 1'b0; req_addr = '0; fault_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", switch_ack, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_fault", rsp_fault, 0);
    chk("rst_sticky", fault_sticky, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Process 3 from reset layout: base 450, limit 150
    do_switch(4'd3, 4'd3);
    translate(32'd10, 32'd460, 1'b0);
    translate(32'd150, 32'd0, 1'b1);
    chk("p3_limit_sticky", fault_sticky, 1);
    clear_sticky();

    // SO reprograms entry 5, then process 5 runs
    do_switch(4'd0, 4'd0);
    cfg(4'd5, 32'd4000, 32'd20);
    chk("so_cfg_no_fault", fault_sticky, 0);
    do_switch(4'd5, 4'd5);
    translate(32'd19, 32'd4019, 1'b0);
    translate(32'd20, 32'd0, 1'b1);
    clear_sticky();

    // Non-SO write is refused and faults; entry 5 must be untouched
    cfg(4'd5, 32'd9999, 32'd9999);
    chk("p5_cfg_sticky", fault_sticky, 1);
    clear_sticky();
    do_switch(4'd0, 4'd0);
    do_switch(4'd5, 4'd5);
    translate(32'd19, 32'd4019, 1'b0);

    // Out-of-range target falls back to the SO
    do_switch(4'd15, 4'd0);
    chk("bad_idx_sticky", fault_sticky, 1);
    clear_sticky();
    translate(32'd1000, 32'd1000, 1'b0);

    // Requests and switch requests during a switch are dropped
    switch_req = 1'b1; switch_idx = 4'd3;
    @(negedge clk);
    chk("busy_in_load", busy, 1);
    req_valid = 1'b1; req_addr = 32'd5; switch_idx = 4'd7;
    @(negedge clk);
    chk("busy_ack", switch_ack, 1);
    chk("busy_req_dropped", rsp_valid, 0);
    req_valid = 1'b0; switch_req = 1'b0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (switch_ack) acks++;
    end
    chk("busy_no_extra_ack", acks, 0);
    chk("busy_cur_idx", cur_idx, 3);
    chk("busy_no_fault", fault_sticky, 0);

    // SO base near the top of the address space: carry-out faults
    do_switch(4'd0, 4'd0);
    cfg(4'd0, 32'hFFFF_FFFC, 32'd0);
    translate(32'd8, 32'd0, 1'b1);
    chk("carry_sticky", fault_sticky, 1);
    clear_sticky();
    translate(32'd3, 32'hFFFF_FFFF, 1'b0);

    // Request and switch at the same edge: old context, response while busy
    e.addr = 32'hFFFF_FFFE; e.fault = 1'b0; e.cyc = cyc + 1;
    q.push_back(e);
    req_valid = 1'b1; req_addr = 32'd2; switch_req = 1'b1; switch_idx = 4'd3;
    @(negedge clk);
    req_valid = 1'b0; switch_req = 1'b0;
    chk("simul_busy", busy, 1);
    @(negedge clk);
    chk("simul_ack", switch_ack, 1);
    chk("simul_cur_idx", cur_idx, 3);
    @(negedge clk);

    // Reset during LOAD aborts the switch
    cfg(4'd1, 32'd1, 32'd1);
    chk("p3_cfg_sticky", fault_sticky, 1);
    switch_req = 1'b1; switch_idx = 4'd5;
    @(negedge clk);
    switch_req = 1'b0;
    chk("abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_rst", busy, 0);
    chk("abort_ack_rst", switch_ack, 0);
    chk("abort_cur_idx", cur_idx, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_addr", rsp_addr, 0);
    chk("abort_sticky", fault_sticky, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (switch_ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_idle", busy, 0);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/partition_addr_translator.md
Name: partition_addr_translator

Overview:
- Parametrised successor to the per-process offset controller. Holds a programmable base/limit table, one entry per process; entry 0 is the SO.
- Runs a context-switch handshake and translates logical addresses to physical addresses with one registered cycle of latency.
- Flags out-of-partition accesses as faults.
- Sits between the ALU address result and data/instruction memory.

Parameters:
- NUM_PROC, 16, number of table entries (SO plus processes).
- PART_SIZE, 150, reset partition size in words.
- ADDR_W, 32, address width.
- IDX_W, $clog2(NUM_PROC), process index width.

Ports:
- Clock  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Switch_Req  in  1  context-switch request, sampled in IDLE only.
- Switch_Idx  in  IDX_W  target process index.
- Switch_Ack  out  1  one-cycle pulse: switch complete.
- Busy  out  1  high while a switch is in progress.
- Cur_Idx  out  IDX_W  active process index.
- Cfg_We  in  1  table write enable.
- Cfg_Idx  in  IDX_W  table entry to write.
- Cfg_Base  in  ADDR_W  base value to write.
- Cfg_Limit  in  ADDR_W  limit value to write.
- Req_Valid  in  1  translation request.
- Req_Addr  in  ADDR_W  logical address.
- Rsp_Valid  out  1  translation result valid.
- Rsp_Addr  out  ADDR_W  physical address.
- Rsp_Fault  out  1  current response faulted.
- Fault_Sticky  out  1  latched fault flag.
- Fault_Clear  in  1  clears Fault_Sticky.

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE; Cur_Idx=0.
  - Active base=0, active limit=0.
  - Switch_Ack=0, Busy=0, Rsp_Valid=0, Rsp_Addr=0, Rsp_Fault=0, Fault_Sticky=0.
  - Table entry i: base=i*PART_SIZE, limit=PART_SIZE. Entry 0: base=0, limit=0.
  - Reset mid-switch or mid-request aborts it; no Ack or Rsp is issued afterwards.
- FSM states: IDLE, LOAD, ACK.
  - IDLE: Switch_Req=1 goes to LOAD and latches Switch_Idx.
  - LOAD: read the table at the latched index into active base/limit; go to ACK.
  - LOAD with latched index >= NUM_PROC: load entry 0 instead, target index becomes 0, set Fault_Sticky.
  - ACK: Cur_Idx updates; Switch_Ack=1 for exactly one cycle; go to IDLE.
  - Switch latency: Req sampled at edge t, Ack high during cycle t+2.
  - Busy=1 in LOAD and ACK.
  - Switch_Req while Busy is ignored; it is not queued.
- Translation (IDLE only):
  - Req_Valid at edge t gives Rsp_Valid=1 after edge t+1, for one cycle per request.
  - Back-to-back requests give back-to-back responses.
  - Rsp_Addr = active_base + Req_Addr, computed ADDR_W+1 wide.
  - Fault when Cur_Idx != 0 and (Req_Addr >= active_limit, or the sum has a carry-out).
  - Cur_Idx == 0 (SO): no limit check, but carry-out still faults.
  - On fault: Rsp_Fault=1, Rsp_Addr=0, Fault_Sticky set.
  - Req_Valid while Busy: dropped, Rsp_Valid stays 0, no fault.
- Configuration:
  - Cfg_We is accepted only when Cur_Idx==0 and state=IDLE.
  - The write lands at the edge.
  - Writing entry 0 updates the active base/limit at the same edge; they take effect for requests sampled at the next edge.
  - Cfg_We with Cur_Idx != 0 is ignored and sets Fault_Sticky.
  - Cfg_We while Busy is ignored; no fault.
  - Cfg_Idx >= NUM_PROC is ignored and sets Fault_Sticky.
- Simultaneous events:
  - Cfg_We and Switch_Req at the same IDLE edge: the write lands and LOAD reads the new value.
  - Fault_Clear and a new fault at the same edge: set wins.
  - Req_Valid and Switch_Req at the same IDLE edge: the request is translated with the old context; its response appears while Busy=1.

Decomposition:
- Shared package partition_pkg holds:
  - state enum {IDLE, LOAD, ACK};
  - localparam SO_IDX=0;
  - function reset_base(i) returning i*PART_SIZE.
- Sub-module partition_table: NUM_PROC-entry register file with one write port, one async read port, and reset init from the package function.
- Top level holds the FSM, active registers, adder/comparator, response registers and fault latch. Target 200-300 lines total.

Test Plan:
- Reset, then switch to 3; Req_Addr=10 -> Ack at t+2, Cur_Idx=3; Rsp_Addr=460, Rsp_Fault=0, one cycle after the request.
- In process 3, Req_Addr=150 -> Rsp_Fault=1, Rsp_Addr=0, Fault_Sticky=1; Fault_Clear then clears it.
- In SO, Cfg_We idx=5, base=4000, limit=20; switch to 5; Req_Addr=19 -> Rsp_Addr=4019. Req_Addr=20 -> fault.
- In process 5, Cfg_We -> table unchanged (verify by switching back through SO), Fault_Sticky=1. Switch_Idx=15 with NUM_PROC=12 -> Cur_Idx=0, Fault_Sticky=1.
- Req_Valid during Busy -> no Rsp_Valid. Switch_Req during Busy -> ignored (only one Ack pulse).
- In SO, base0=2^32-4, Req_Addr=8 (carry-out) -> fault. Assert Reset_n low during LOAD -> all outputs return to reset values immediately and no Ack follows.
